// File: rtl/gbpt_sat.sv
// rtl/gbpt_sat.sv - global branch predictor table with per-lane saturating counters
//
// Purpose: gshare-style predictor table. Set = fetch index ^ fold(gh) ^ fold(asid).
// Each set holds LANES saturating counters; the prediction is each counter's MSB.
// A self-clearing sweep initialises every set after reset. Training runs through a
// two-stage read-modify-write pipeline with U1->U0 forwarding.
//
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   arch_asid                    current ASID, folded into both read and update hashes
//   read_req_valid/fetch_index/gh   prediction request
//   read_resp_valid/taken_by_lane   response, one cycle after the request
//   update_valid/pc/gh/taken     resolved-branch training event
//   init_busy                    init sweep in progress
module gbpt_sat #(
  parameter int SETS      = 512,
  parameter int LANES     = 8,
  parameter int GH_BITS   = 9,
  parameter int CTR_BITS  = 2,
  parameter int ASID_BITS = 16,
  parameter int PC_BITS   = 38
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [ASID_BITS-1:0]          arch_asid,
  input  logic                          read_req_valid,
  input  logic [$clog2(SETS)-1:0]       read_req_fetch_index,
  input  logic [GH_BITS-1:0]            read_req_gh,
  output logic                          read_resp_valid,
  output logic [LANES-1:0]              read_resp_taken_by_lane,
  input  logic                          update_valid,
  input  logic [PC_BITS-1:0]            update_pc,
  input  logic [GH_BITS-1:0]            update_gh,
  input  logic                          update_taken,
  output logic                          init_busy
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int LANE_BITS  = $clog2(LANES);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [CTR_BITS-1:0]   CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CTR_ZERO = '0;
  localparam logic [INDEX_BITS-1:0] LAST_SET = INDEX_BITS'(SETS - 1);

  // Folding is XOR of INDEX_BITS-wide chunks; bit i lands on position i mod INDEX_BITS,
  // which gives the zero-padded last chunk for free.
  function automatic logic [INDEX_BITS-1:0] hash_set(
    input logic [INDEX_BITS-1:0] idx,
    input logic [GH_BITS-1:0]    gh,
    input logic [ASID_BITS-1:0]  asid
  );
    logic [INDEX_BITS-1:0] h;
    h = idx;
    for (int i = 0; i < GH_BITS; i++)   h[i % INDEX_BITS] = h[i % INDEX_BITS] ^ gh[i];
    for (int i = 0; i < ASID_BITS; i++) h[i % INDEX_BITS] = h[i % INDEX_BITS] ^ asid[i];
    return h;
  endfunction

  logic [CTR_BITS-1:0] mem [SETS][LANES];

  logic [0:0]            state;
  logic [INDEX_BITS-1:0] sweep_idx;

  logic                  u1_valid;
  logic [INDEX_BITS-1:0] u1_set;
  logic [LANE_BITS-1:0]  u1_lane;
  logic [CTR_BITS-1:0]   u1_ctr;
  logic                  u1_taken;
  logic [CTR_BITS-1:0]   u1_new;

  logic [INDEX_BITS-1:0] u0_set;
  logic [LANE_BITS-1:0]  u0_lane;
  logic [CTR_BITS-1:0]   u0_ctr;
  logic [INDEX_BITS-1:0] rd_set;
  logic                  ready;
  logic                  unused_pc;

  assign unused_pc = ^update_pc;
  assign ready     = (state == ST_READY);
  assign init_busy = (state == ST_INIT);

  always_comb begin
    u1_new = u1_ctr;
    if (u1_taken) begin
      if (u1_ctr != CTR_MAX) u1_new = u1_ctr + CTR_BITS'(1);
    end else begin
      if (u1_ctr != CTR_ZERO) u1_new = u1_ctr - CTR_BITS'(1);
    end
  end

  // U0 takes U1's result when both address the same counter, so back-to-back
  // updates to one counter accumulate instead of overwriting each other.
  always_comb begin
    u0_set  = hash_set(update_pc[LANE_BITS +: INDEX_BITS], update_gh, arch_asid);
    u0_lane = update_pc[LANE_BITS-1:0];
    rd_set  = hash_set(read_req_fetch_index, read_req_gh, arch_asid);
    if (u1_valid && (u1_set == u0_set) && (u1_lane == u0_lane)) u0_ctr = u1_new;
    else                                                         u0_ctr = mem[u0_set][u0_lane];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                   <= ST_INIT;
      sweep_idx               <= '0;
      u1_valid                <= 1'b0;
      u1_set                  <= '0;
      u1_lane                 <= '0;
      u1_ctr                  <= '0;
      u1_taken                <= 1'b0;
      read_resp_valid         <= 1'b0;
      read_resp_taken_by_lane <= '0;
    end else begin
      if (state == ST_INIT) begin
        sweep_idx <= sweep_idx + INDEX_BITS'(1);
        if (sweep_idx == LAST_SET) state <= ST_READY;
      end
      u1_valid <= update_valid && ready;
      u1_set   <= u0_set;
      u1_lane  <= u0_lane;
      u1_ctr   <= u0_ctr;
      u1_taken <= update_taken;
      read_resp_valid <= read_req_valid && ready;
      // Array read happens before this edge's write: read-first on collisions.
      for (int l = 0; l < LANES; l++)
        read_resp_taken_by_lane[l] <= read_req_valid && ready && mem[rd_set][l][CTR_BITS-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == ST_INIT) begin
        for (int l = 0; l < LANES; l++) mem[sweep_idx][l] <= CTR_INIT;
      end else if (u1_valid) begin
        mem[u1_set][u1_lane] <= u1_new;
      end
    end
  end

endmodule
